time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_pkg.sv | 38 +++
 rtl/time_set_ctrl_if.sv | 33 +++
 rtl/key_repeat.sv | 53 +++++
 rtl/time_set_ctrl.sv | 128 ++++++++++++
 tb/tb_time_set_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/time_pkg.sv
// Shared field widths, limits, state encoding and the wrap-around step helper
// for the time-set editor.
package time_pkg;

    localparam int unsigned HOUR_W     = 5;
    localparam int unsigned MIN_W      = 6;
    localparam int unsigned SEC_W      = 6;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned MIN_MAX    = 59;
    localparam int unsigned SEC_MAX    = 59;
    localparam int unsigned HOUR12_MAX = 12;
    localparam int unsigned HOUR24_MAX = 23;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_PM     = 3'd1,
        ST_HOUR   = 3'd2,
        ST_MINUTE = 3'd3,
        ST_SECOND = 3'd4
    } state_e;

    typedef struct packed {
        logic              is_pm;
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
        logic [SEC_W-1:0]  seconds;
    } time_t;

    // Step v by one inside [lo, hi]; out-of-range values land on the wrap target.
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] lo,
                                             input logic [5:0] hi, input logic inc);
        if (inc) begin
            return (v >= hi) ? lo : v + 6'd1;
        end
        return (v <= lo || v > hi) ? hi : v - 6'd1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button, live-time preload and edited-time signals of the time-set editor.
interface time_set_ctrl_if;
    import time_pkg::*;

    logic               set_enable;
    logic               set;
    logic               up;
    logic               down;
    logic               cancel;
    logic               cur_pm;
    logic [HOUR_W-1:0]  cur_hours;
    logic [MIN_W-1:0]   cur_minutes;
    logic [SEC_W-1:0]   cur_seconds;
    logic               propagate;
    logic               is_pm;
    logic [HOUR_W-1:0]  hours;
    logic [MIN_W-1:0]   minutes;
    logic [SEC_W-1:0]   seconds;
    logic [STATE_W-1:0] state;

    modport master (
        output set_enable, set, up, down, cancel,
        output cur_pm, cur_hours, cur_minutes, cur_seconds,
        input  propagate, is_pm, hours, minutes, seconds, state
    );

    modport slave (
        input  set_enable, set, up, down, cancel,
        input  cur_pm, cur_hours, cur_minutes, cur_seconds,
        output propagate, is_pm, hours, minutes, seconds, state
    );

endinterface

// File: rtl/key_repeat.sv
// Rising-edge detect with hold-to-repeat: one step on press, another after
// REPEAT_DELAY held cycles, then one every REPEAT_RATE cycles until release.
module key_repeat #(
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic btn,
    output logic step_c
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Down-counter holds cycles left until the next repeat step.
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        step_c = 1'b0;
        if (en) begin
            prev_d = btn;
            if (btn && !prev_q) begin
                step_c = 1'b1;
                cnt_d  = CNT_W'(REPEAT_DELAY - 1);
            end else if (btn) begin
                if (cnt_q == '0) begin
                    step_c = 1'b1;
                    cnt_d  = CNT_W'(REPEAT_RATE - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set editor: walks PM/HOUR/MINUTE/SECOND fields on set, steps them with
// up/down (auto-repeat), and pulses propagate when the last field is left.
module time_set_ctrl
    import time_pkg::*;
#(
    parameter int unsigned HOUR24       = 0,
    parameter int unsigned SECONDS_EN   = 0,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10,
    parameter int unsigned TIMEOUT      = 1000
) (
    input  logic            clk,
    input  logic            reset,
    time_set_ctrl_if.slave  ctl
);

    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned HOUR_LO  = (HOUR24 != 0) ? 0 : 1;
    localparam int unsigned HOUR_HI  = (HOUR24 != 0) ? HOUR24_MAX : HOUR12_MAX;
    localparam state_e      FIRST_ST = (HOUR24 != 0) ? ST_HOUR : ST_PM;
    localparam time_t       FIELDS_RST = '{
        is_pm:   1'b0,
        hours:   (HOUR24 != 0) ? HOUR_W'(0) : HOUR_W'(HOUR12_MAX),
        minutes: '0,
        seconds: '0
    };

    state_e           state_q, state_d;
    time_t            fields_q, fields_d;
    logic             propagate_q, propagate_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic up_step_c, dn_step_c;
    logic inc_c, dec_c, any_btn_c;
    state_e nxt_c;

    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
        .clk(clk), .reset(reset), .en(ctl.set_enable), .btn(ctl.up), .step_c(up_step_c)
    );

    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
        .clk(clk), .reset(reset), .en(ctl.set_enable), .btn(ctl.down), .step_c(dn_step_c)
    );

    // Simultaneous up and down cancel each other out.
    assign inc_c     = up_step_c & ~ctl.down;
    assign dec_c     = dn_step_c & ~ctl.up;
    assign any_btn_c = ctl.set | ctl.up | ctl.down | ctl.cancel;

    always_comb begin
        case (state_q)
            ST_PM:     nxt_c = ST_HOUR;
            ST_HOUR:   nxt_c = ST_MINUTE;
            ST_MINUTE: nxt_c = (SECONDS_EN != 0) ? ST_SECOND : ST_IDLE;
            default:   nxt_c = ST_IDLE;
        endcase
    end

    // Priority in edit states: cancel, then set, then up/down stepping.
    always_comb begin
        state_d     = state_q;
        fields_d    = fields_q;
        propagate_d = 1'b0;
        tmo_d       = tmo_q;
        if (ctl.set_enable) begin
            if (state_q == ST_IDLE) begin
                tmo_d = '0;
                if (ctl.set) begin
                    fields_d.is_pm   = (HOUR24 != 0) ? 1'b0 : ctl.cur_pm;
                    fields_d.hours   = ctl.cur_hours;
                    fields_d.minutes = ctl.cur_minutes;
                    fields_d.seconds = ctl.cur_seconds;
                    state_d          = FIRST_ST;
                end
            end else if (ctl.cancel) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else if (ctl.set) begin
                state_d     = nxt_c;
                propagate_d = (nxt_c == ST_IDLE);
                tmo_d       = '0;
            end else begin
                if (inc_c || dec_c) begin
                    case (state_q)
                        ST_PM:     fields_d.is_pm = ~fields_q.is_pm;
                        ST_HOUR:   fields_d.hours = HOUR_W'(wrap_step(6'(fields_q.hours),
                                       6'(HOUR_LO), 6'(HOUR_HI), inc_c));
                        ST_MINUTE: fields_d.minutes = MIN_W'(wrap_step(6'(fields_q.minutes),
                                       6'd0, 6'(MIN_MAX), inc_c));
                        ST_SECOND: fields_d.seconds = SEC_W'(wrap_step(6'(fields_q.seconds),
                                       6'd0, 6'(SEC_MAX), inc_c));
                        default: ;
                    endcase
                end
                if (any_btn_c) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fields_q    <= FIELDS_RST;
            propagate_q <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            fields_q    <= fields_d;
            propagate_q <= propagate_d;
            tmo_q       <= tmo_d;
        end
    end

    assign ctl.state     = state_q;
    assign ctl.propagate = propagate_q;
    assign ctl.hours     = fields_q.hours;
    assign ctl.minutes   = fields_q.minutes;
    assign ctl.seconds   = fields_q.seconds;
    assign ctl.is_pm     = (HOUR24 != 0) ? (fields_q.hours >= HOUR_W'(HOUR12_MAX)) : fields_q.is_pm;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench: a 12-hour editor (A) and a 24-hour editor with seconds (B)
// share one stimulus; expectations are queued per cycle and compared after the edge.
module tb_time_set_ctrl;
    import time_pkg::*;

    localparam int unsigned DLY = 5;
    localparam int unsigned RT  = 2;
    localparam int unsigned TMO = 20;

    logic clk = 1'b0;
    logic reset;
    logic set_enable, set, up, down, cancel, cur_pm;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes, cur_seconds;

    always #5 clk = ~clk;

    time_set_ctrl_if if_a();
    time_set_ctrl_if if_b();

    assign if_a.set_enable = set_enable;  assign if_b.set_enable = set_enable;
    assign if_a.set = set;                assign if_b.set = set;
    assign if_a.up = up;                  assign if_b.up = up;
    assign if_a.down = down;              assign if_b.down = down;
    assign if_a.cancel = cancel;          assign if_b.cancel = cancel;
    assign if_a.cur_pm = cur_pm;          assign if_b.cur_pm = cur_pm;
    assign if_a.cur_hours = cur_hours;    assign if_b.cur_hours = cur_hours;
    assign if_a.cur_minutes = cur_minutes; assign if_b.cur_minutes = cur_minutes;
    assign if_a.cur_seconds = cur_seconds; assign if_b.cur_seconds = cur_seconds;

    time_set_ctrl #(.HOUR24(0), .SECONDS_EN(0), .REPEAT_DELAY(DLY), .REPEAT_RATE(RT),
                    .TIMEOUT(TMO)) dut_a (.clk(clk), .reset(reset), .ctl(if_a));

    time_set_ctrl #(.HOUR24(1), .SECONDS_EN(1), .REPEAT_DELAY(DLY), .REPEAT_RATE(RT),
                    .TIMEOUT(TMO)) dut_b (.clk(clk), .reset(reset), .ctl(if_b));

    typedef struct {
        int         tag;
        bit         dut_b;
        logic [2:0] st;
        logic       prop;
        logic       pm;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } exp_t;

    typedef struct {
        logic       set, up, down, cancel;
        logic [2:0] st;
        logic       prop;
        logic       pm;
        logic [4:0] h;
        logic [5:0] m;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add_vec(input logic s_i, input logic u_i, input logic d_i, input logic c_i,
                           input logic [2:0] st, input logic prop, input logic pm,
                           input logic [4:0] h, input logic [5:0] m);
        vec_t v;
        v.set = s_i; v.up = u_i; v.down = d_i; v.cancel = c_i;
        v.st = st; v.prop = prop; v.pm = pm; v.h = h; v.m = m;
        tbl.push_back(v);
    endtask

    task automatic expect_out(input int tag, input bit which_b, input logic [2:0] st,
                              input logic prop, input logic pm, input logic [4:0] h,
                              input logic [5:0] m, input logic [5:0] s);
        exp_t e;
        e.tag = tag; e.dut_b = which_b; e.st = st; e.prop = prop;
        e.pm = pm; e.h = h; e.m = m; e.s = s;
        sb.push_back(e);
    endtask

    task automatic check_pending();
        exp_t       e;
        logic [2:0] st;
        logic       pr, pm;
        logic [4:0] h;
        logic [5:0] m, s;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut_b) begin
                st = if_b.state; pr = if_b.propagate; pm = if_b.is_pm;
                h = if_b.hours; m = if_b.minutes; s = if_b.seconds;
            end else begin
                st = if_a.state; pr = if_a.propagate; pm = if_a.is_pm;
                h = if_a.hours; m = if_a.minutes; s = if_a.seconds;
            end
            total++;
            if ({st, pr, pm, h, m, s} !== {e.st, e.prop, e.pm, e.h, e.m, e.s}) begin
                bad++;
                $display("FAIL chk%0d dut_%s: got st=%0d prop=%0b pm=%0b %0d:%0d:%0d want st=%0d prop=%0b pm=%0b %0d:%0d:%0d",
                         e.tag, e.dut_b ? "b24" : "a12", st, pr, pm, h, m, s,
                         e.st, e.prop, e.pm, e.h, e.m, e.s);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_pending();
    endtask

    task automatic drive(input logic s_i, input logic u_i, input logic d_i, input logic c_i);
        set = s_i; up = u_i; down = d_i; cancel = c_i;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        set_enable = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic int steps_upto(input int k);
        int n = 0;
        for (int j = 0; j <= k; j++) begin
            if (j == 0 || (j >= int'(DLY) && ((j - int'(DLY)) % int'(RT)) == 0)) n++;
        end
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_enable = 1'b1;
        drive(0, 0, 0, 0);
        cur_pm = 1'b0; cur_hours = 5'd0; cur_minutes = 6'd0; cur_seconds = 6'd0;

        // Reset values on both variants.
        expect_out(1, 0, 3'd0, 0, 0, 5'd12, 6'd0, 6'd0);
        expect_out(2, 1, 3'd0, 0, 0, 5'd0, 6'd0, 6'd0);
        tick();
        reset = 1'b0;

        // 11:58 PM edit walk on the 12-hour variant.
        cur_pm = 1'b1; cur_hours = 5'd11; cur_minutes = 6'd58; cur_seconds = 6'd0;
        add_vec(1,0,0,0, 3'd1,0,1,5'd11,6'd58);
        add_vec(0,1,0,0, 3'd1,0,0,5'd11,6'd58);
        add_vec(0,0,0,0, 3'd1,0,0,5'd11,6'd58);
        add_vec(0,0,1,0, 3'd1,0,1,5'd11,6'd58);
        add_vec(0,0,0,0, 3'd1,0,1,5'd11,6'd58);
        add_vec(1,0,0,0, 3'd2,0,1,5'd11,6'd58);
        add_vec(0,1,0,0, 3'd2,0,1,5'd12,6'd58);
        add_vec(0,0,0,0, 3'd2,0,1,5'd12,6'd58);
        add_vec(0,1,0,0, 3'd2,0,1,5'd1, 6'd58);
        add_vec(0,0,0,0, 3'd2,0,1,5'd1, 6'd58);
        add_vec(0,0,1,0, 3'd2,0,1,5'd12,6'd58);
        add_vec(0,0,0,0, 3'd2,0,1,5'd12,6'd58);
        add_vec(0,1,1,0, 3'd2,0,1,5'd12,6'd58);
        add_vec(0,0,0,0, 3'd2,0,1,5'd12,6'd58);
        add_vec(1,0,0,0, 3'd3,0,1,5'd12,6'd58);
        add_vec(0,1,0,0, 3'd3,0,1,5'd12,6'd59);
        add_vec(0,0,0,0, 3'd3,0,1,5'd12,6'd59);
        add_vec(0,1,0,0, 3'd3,0,1,5'd12,6'd0);
        add_vec(0,0,0,0, 3'd3,0,1,5'd12,6'd0);
        add_vec(0,1,0,0, 3'd3,0,1,5'd12,6'd1);
        add_vec(0,0,0,0, 3'd3,0,1,5'd12,6'd1);
        add_vec(1,0,0,0, 3'd0,1,1,5'd12,6'd1);
        add_vec(0,0,0,0, 3'd0,0,1,5'd12,6'd1);
        add_vec(0,1,0,0, 3'd0,0,1,5'd12,6'd1);
        add_vec(0,0,0,0, 3'd0,0,1,5'd12,6'd1);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].set, tbl[i].up, tbl[i].down, tbl[i].cancel);
            expect_out(100 + i, 0, tbl[i].st, tbl[i].prop, tbl[i].pm, tbl[i].h, tbl[i].m, 6'd0);
            tick();
        end

        // 24-hour hour wrap with derived is_pm, then cancel.
        do_reset();
        cur_pm = 1'b0; cur_hours = 5'd23; cur_minutes = 6'd10; cur_seconds = 6'd0;
        drive(1,0,0,0); expect_out(200, 1, 3'd2, 0, 1, 5'd23, 6'd10, 6'd0); tick();
        drive(0,0,0,0); expect_out(201, 1, 3'd2, 0, 1, 5'd23, 6'd10, 6'd0); tick();
        drive(0,1,0,0); expect_out(202, 1, 3'd2, 0, 0, 5'd0,  6'd10, 6'd0); tick();
        drive(0,0,0,0); expect_out(203, 1, 3'd2, 0, 0, 5'd0,  6'd10, 6'd0); tick();
        drive(0,0,1,0); expect_out(204, 1, 3'd2, 0, 1, 5'd23, 6'd10, 6'd0); tick();
        drive(0,0,0,0); expect_out(205, 1, 3'd2, 0, 1, 5'd23, 6'd10, 6'd0); tick();
        drive(0,0,0,1); expect_out(206, 1, 3'd0, 0, 1, 5'd23, 6'd10, 6'd0); tick();

        // Auto-repeat from 58 in MINUTE, then idle timeout.
        do_reset();
        cur_pm = 1'b0; cur_hours = 5'd5; cur_minutes = 6'd58; cur_seconds = 6'd0;
        drive(1,0,0,0); expect_out(300, 0, 3'd1, 0, 0, 5'd5, 6'd58, 6'd0); tick();
        drive(1,0,0,0); expect_out(301, 0, 3'd2, 0, 0, 5'd5, 6'd58, 6'd0); tick();
        drive(1,0,0,0); expect_out(302, 0, 3'd3, 0, 0, 5'd5, 6'd58, 6'd0); tick();
        for (int k = 0; k < 12; k++) begin
            drive(0,1,0,0);
            expect_out(310 + k, 0, 3'd3, 0, 0, 5'd5, 6'((58 + steps_upto(k)) % 60), 6'd0);
            tick();
        end
        for (int i = 1; i <= int'(TMO); i++) begin
            drive(0,0,0,0);
            expect_out(330 + i, 0, (i < int'(TMO)) ? 3'd3 : 3'd0, 0, 0, 5'd5, 6'd3, 6'd0);
            tick();
        end

        // Cancel mid-HOUR, then cancel beating set in MINUTE.
        do_reset();
        cur_pm = 1'b1; cur_hours = 5'd5; cur_minutes = 6'd30; cur_seconds = 6'd0;
        drive(1,0,0,0); expect_out(400, 0, 3'd1, 0, 1, 5'd5, 6'd30, 6'd0); tick();
        drive(1,0,0,0); expect_out(401, 0, 3'd2, 0, 1, 5'd5, 6'd30, 6'd0); tick();
        drive(0,1,0,0); expect_out(402, 0, 3'd2, 0, 1, 5'd6, 6'd30, 6'd0); tick();
        drive(0,0,0,1); expect_out(403, 0, 3'd0, 0, 1, 5'd6, 6'd30, 6'd0); tick();
        drive(1,0,0,0); expect_out(404, 0, 3'd1, 0, 1, 5'd5, 6'd30, 6'd0); tick();
        drive(1,0,0,0); expect_out(405, 0, 3'd2, 0, 1, 5'd5, 6'd30, 6'd0); tick();
        drive(1,0,0,0); expect_out(406, 0, 3'd3, 0, 1, 5'd5, 6'd30, 6'd0); tick();
        drive(1,0,0,1); expect_out(407, 0, 3'd0, 0, 1, 5'd5, 6'd30, 6'd0); tick();
        drive(0,0,0,0); expect_out(408, 0, 3'd0, 0, 1, 5'd5, 6'd30, 6'd0); tick();

        // set_enable low freezes fields, state and the repeat counter.
        do_reset();
        cur_pm = 1'b0; cur_hours = 5'd5; cur_minutes = 6'd10; cur_seconds = 6'd0;
        repeat (3) begin drive(1,0,0,0); tick(); end
        drive(0,1,0,0); expect_out(500, 0, 3'd3, 0, 0, 5'd5, 6'd11, 6'd0); tick();
        expect_out(501, 0, 3'd3, 0, 0, 5'd5, 6'd11, 6'd0); tick();
        expect_out(502, 0, 3'd3, 0, 0, 5'd5, 6'd11, 6'd0); tick();
        set_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set = (i == 4);
            expect_out(510 + i, 0, 3'd3, 0, 0, 5'd5, 6'd11, 6'd0);
            tick();
        end
        set = 1'b0;
        set_enable = 1'b1;
        expect_out(520, 0, 3'd3, 0, 0, 5'd5, 6'd11, 6'd0); tick();
        expect_out(521, 0, 3'd3, 0, 0, 5'd5, 6'd11, 6'd0); tick();
        expect_out(522, 0, 3'd3, 0, 0, 5'd5, 6'd12, 6'd0); tick();
        drive(0,0,0,0); tick();

        // Asynchronous reset in the middle of a SECOND edit.
        do_reset();
        cur_pm = 1'b0; cur_hours = 5'd7; cur_minutes = 6'd20; cur_seconds = 6'd30;
        drive(1,0,0,0); expect_out(600, 1, 3'd2, 0, 0, 5'd7, 6'd20, 6'd30); tick();
        drive(1,0,0,0); expect_out(601, 1, 3'd3, 0, 0, 5'd7, 6'd20, 6'd30); tick();
        drive(1,0,0,0); expect_out(602, 1, 3'd4, 0, 0, 5'd7, 6'd20, 6'd30); tick();
        drive(0,1,0,0); expect_out(603, 1, 3'd4, 0, 0, 5'd7, 6'd20, 6'd31); tick();
        drive(0,0,0,0);
        #2;
        reset = 1'b1;
        #1;
        expect_out(604, 1, 3'd0, 0, 0, 5'd0, 6'd0, 6'd0);
        check_pending();
        drive(1,0,0,0); expect_out(605, 1, 3'd0, 0, 0, 5'd0, 6'd0, 6'd0); tick();
        reset = 1'b0;
        drive(0,0,0,0); expect_out(606, 1, 3'd0, 0, 0, 5'd0, 6'd0, 6'd0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
